// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register and operand-resolution stage feeding the ALU.
// Latches decoded fields and register-file reads, forwards from EX/MEM and
// MEM/WB, and selects the ALU operands, store data and writeback tags.
module idex_operand_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [WORD_W-1:0] id_rdata1,
  input  logic [WORD_W-1:0] id_rdata2,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic              id_asel,
  input  logic [1:0]        id_bsel,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic              id_regwen,
  input  logic              exmem_regwen,
  input  logic              memwb_regwen,
  input  logic [REG_W-1:0]  exmem_wsel,
  input  logic [REG_W-1:0]  memwb_wsel,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic [WORD_W-1:0] memwb_result,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwen,
  output logic [WORD_W-1:0] ex_store_data,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit
);

  // aluop_t encoding of the shift-left operation, used as the bubble opcode.
  localparam logic [OP_W-1:0] ALU_SLL = '0;

  // Port_B source encodings.
  typedef enum logic [1:0] {
    BSEL_RT    = 2'd0,
    BSEL_SEXT  = 2'd1,
    BSEL_ZEXT  = 2'd2,
    BSEL_SHAMT = 2'd3
  } bsel_e;

  logic              r_valid;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [WORD_W-1:0] r_rdata1;
  logic [WORD_W-1:0] r_rdata2;
  logic [15:0]       r_imm;
  logic [4:0]        r_shamt;
  logic [OP_W-1:0]   r_aluop;
  logic              r_asel;
  logic [1:0]        r_bsel;
  logic [REG_W-1:0]  r_wsel;
  logic              r_regwen;

  logic              w_ex_hit_rs;
  logic              w_wb_hit_rs;
  logic              w_ex_hit_rt;
  logic              w_wb_hit_rt;
  logic [WORD_W-1:0] w_res_rs;
  logic [WORD_W-1:0] w_res_rt;
  logic [WORD_W-1:0] w_alu_b;

  // Forwarding hit detection; register 0 is hard-wired and never forwarded.
  assign w_ex_hit_rs = exmem_regwen && (exmem_wsel == r_rs) && (r_rs != '0);
  assign w_wb_hit_rs = memwb_regwen && (memwb_wsel == r_rs) && (r_rs != '0);
  assign w_ex_hit_rt = exmem_regwen && (exmem_wsel == r_rt) && (r_rt != '0);
  assign w_wb_hit_rt = memwb_regwen && (memwb_wsel == r_rt) && (r_rt != '0);

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  assign w_res_rs = w_ex_hit_rs ? exmem_result :
                    w_wb_hit_rs ? memwb_result : r_rdata1;
  assign w_res_rt = w_ex_hit_rt ? exmem_result :
                    w_wb_hit_rt ? memwb_result : r_rdata2;

  // Pipeline register: reset/flush load a bubble, en captures, stall holds
  // but folds forwarded values into the latched operands.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!nRST || flush) begin
      r_valid  <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_shamt  <= '0;
      r_aluop  <= ALU_SLL;
      r_asel   <= 1'b0;
      r_bsel   <= '0;
      r_wsel   <= '0;
      r_regwen <= 1'b0;
    end else if (en) begin
      r_valid  <= id_valid;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_shamt  <= id_shamt;
      r_aluop  <= id_aluop;
      r_asel   <= id_asel;
      r_bsel   <= id_bsel;
      r_wsel   <= id_wsel;
      r_regwen <= id_regwen;
    end else begin
      // Keep a forwarded operand alive after its producer retires.
      r_rdata1 <= w_res_rs;
      r_rdata2 <= w_res_rt;
    end
  end

  // Port_B operand mux: rt, sign/zero-extended immediate, or shift amount.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_alu_b unassigned,
    // which would otherwise infer a latch.
    w_alu_b = w_res_rt;
    case (bsel_e'(r_bsel))
      BSEL_RT:    w_alu_b = w_res_rt;
      BSEL_SEXT:  w_alu_b = {{(WORD_W-16){r_imm[15]}}, r_imm};
      BSEL_ZEXT:  w_alu_b = {{(WORD_W-16){1'b0}}, r_imm};
      BSEL_SHAMT: w_alu_b = {{(WORD_W-5){1'b0}}, r_shamt};
      default:    w_alu_b = w_res_rt;
    endcase
  end

  assign alu_a         = r_asel ? w_res_rt : w_res_rs;
  assign alu_b         = w_alu_b;
  assign alu_op        = r_aluop;
  assign ex_valid      = r_valid;
  assign ex_wsel       = r_wsel;
  assign ex_regwen     = r_regwen & r_valid;
  assign ex_store_data = w_res_rt;
  assign fwd_a_hit     = w_ex_hit_rs | w_wb_hit_rs;
  assign fwd_b_hit     = w_ex_hit_rt | w_wb_hit_rt;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Self-checking bench for idex_operand_stage: directed vector table plus
// hand-written reset, stall-forwarding and flush sequences.
module tb_idex_operand_stage;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd0;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd2;

  logic              CLK = 1'b0;
  logic              nRST, en, flush, id_valid, id_asel, id_regwen;
  logic [REG_W-1:0]  id_rs, id_rt, id_wsel, exmem_wsel, memwb_wsel;
  logic [WORD_W-1:0] id_rdata1, id_rdata2, exmem_result, memwb_result;
  logic [15:0]       id_imm;
  logic [4:0]        id_shamt;
  logic [OP_W-1:0]   id_aluop;
  logic [1:0]        id_bsel;
  logic              exmem_regwen, memwb_regwen;
  logic [WORD_W-1:0] alu_a, alu_b, ex_store_data;
  logic [OP_W-1:0]   alu_op;
  logic              ex_valid, ex_regwen, fwd_a_hit, fwd_b_hit;
  logic [REG_W-1:0]  ex_wsel;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  idex_operand_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_wsel(id_wsel),
    .id_regwen(id_regwen), .exmem_regwen(exmem_regwen),
    .memwb_regwen(memwb_regwen), .exmem_wsel(exmem_wsel),
    .memwb_wsel(memwb_wsel), .exmem_result(exmem_result),
    .memwb_result(memwb_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_valid(ex_valid), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_store_data(ex_store_data),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit)
  );

  typedef struct {
    string             name;
    logic              en, flush, valid, asel, regwen;
    logic [REG_W-1:0]  rs, rt, wsel;
    logic [WORD_W-1:0] rd1, rd2;
    logic [15:0]       imm;
    logic [4:0]        shamt;
    logic [OP_W-1:0]   op;
    logic [1:0]        bsel;
    logic              xw, mw;
    logic [REG_W-1:0]  xs, ms;
    logic [WORD_W-1:0] xr, mr;
    logic [WORD_W-1:0] ea, eb, est;
    logic [OP_W-1:0]   eop;
    logic              ev, erw, efa, efb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t base(input string name);
    vec_t v;
    v.name = name; v.en = 1'b1; v.flush = 1'b0; v.valid = 1'b1;
    v.asel = 1'b0; v.regwen = 1'b1; v.rs = '0; v.rt = '0; v.wsel = 5'd3;
    v.rd1 = '0; v.rd2 = '0; v.imm = '0; v.shamt = '0; v.op = ALU_ADD;
    v.bsel = 2'd0; v.xw = 1'b0; v.mw = 1'b0; v.xs = '0; v.ms = '0;
    v.xr = '0; v.mr = '0; v.ea = '0; v.eb = '0; v.est = '0;
    v.eop = ALU_ADD; v.ev = 1'b1; v.erw = 1'b1; v.efa = 1'b0; v.efb = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    en = v.en; flush = v.flush; id_valid = v.valid; id_asel = v.asel;
    id_regwen = v.regwen; id_rs = v.rs; id_rt = v.rt; id_wsel = v.wsel;
    id_rdata1 = v.rd1; id_rdata2 = v.rd2; id_imm = v.imm;
    id_shamt = v.shamt; id_aluop = v.op; id_bsel = v.bsel;
    exmem_regwen = v.xw; exmem_wsel = v.xs; exmem_result = v.xr;
    memwb_regwen = v.mw; memwb_wsel = v.ms; memwb_result = v.mr;
  endtask

  // Clock one edge and sample outputs 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".alu_a"}, alu_a, 32'h0);
    check({tag, ".alu_b"}, alu_b, 32'h0);
    check({tag, ".alu_op"}, 32'(alu_op), 32'(ALU_SLL));
    check({tag, ".ex_valid"}, 32'(ex_valid), 32'h0);
    check({tag, ".ex_regwen"}, 32'(ex_regwen), 32'h0);
  endtask

  initial begin
    vec_t v;

    // Directed vector table.
    v = base("add"); v.rs = 1; v.rt = 2; v.rd1 = 32'h5; v.rd2 = 32'h7;
    v.ea = 32'h5; v.eb = 32'h7; v.est = 32'h7; vecs.push_back(v);

    // Stall with both stages matching rs: EX/MEM wins.
    v = base("fwd_exmem"); v.en = 0; v.rs = 9; v.rd1 = 32'hDEAD;
    v.xw = 1; v.xs = 1; v.xr = 32'h100; v.mw = 1; v.ms = 1; v.mr = 32'h200;
    v.ea = 32'h100; v.eb = 32'h7; v.est = 32'h7; v.efa = 1; vecs.push_back(v);

    // EX/MEM drops out: MEM/WB takes over.
    v = base("fwd_memwb"); v.en = 0; v.mw = 1; v.ms = 1; v.mr = 32'h200;
    v.ea = 32'h200; v.eb = 32'h7; v.est = 32'h7; v.efa = 1; vecs.push_back(v);

    // rs = 0 is never forwarded even when EX/MEM writes r0.
    v = base("rs_zero"); v.rs = 0; v.rt = 2; v.rd1 = 32'h11; v.rd2 = 32'h7;
    v.xw = 1; v.xs = 0; v.xr = 32'hFFFF;
    v.ea = 32'h11; v.eb = 32'h7; v.est = 32'h7; vecs.push_back(v);

    v = base("imm_sext"); v.rs = 1; v.rt = 2; v.rd1 = 32'h5; v.rd2 = 32'h7;
    v.imm = 16'h8000; v.bsel = 1;
    v.ea = 32'h5; v.eb = 32'hFFFF_8000; v.est = 32'h7; vecs.push_back(v);

    v = base("imm_zext"); v.rs = 1; v.rt = 2; v.rd1 = 32'h5; v.rd2 = 32'h7;
    v.imm = 16'h8000; v.bsel = 2;
    v.ea = 32'h5; v.eb = 32'h0000_8000; v.est = 32'h7; vecs.push_back(v);

    v = base("sll"); v.rt = 4; v.rd2 = 32'h3; v.shamt = 5'd4; v.asel = 1;
    v.bsel = 3; v.op = ALU_SLL; v.eop = ALU_SLL;
    v.ea = 32'h3; v.eb = 32'h4; v.est = 32'h3; vecs.push_back(v);

    v = base("fwd_both"); v.rs = 5; v.rt = 5; v.rd1 = 32'h1; v.rd2 = 32'h2;
    v.xw = 1; v.xs = 5; v.xr = 32'hAAAA; v.mw = 1; v.ms = 5; v.mr = 32'hBBBB;
    v.ea = 32'hAAAA; v.eb = 32'hAAAA; v.est = 32'hAAAA; v.efa = 1; v.efb = 1;
    vecs.push_back(v);

    v = base("rt_memwb"); v.rs = 1; v.rt = 6; v.rd1 = 32'h5; v.rd2 = 32'h9;
    v.mw = 1; v.ms = 6; v.mr = 32'h1234;
    v.ea = 32'h5; v.eb = 32'h1234; v.est = 32'h1234; v.efb = 1;
    vecs.push_back(v);

    v = base("no_regwen"); v.regwen = 0; v.erw = 0; vecs.push_back(v);

    v = base("invalid"); v.valid = 0; v.ev = 0; v.erw = 0; vecs.push_back(v);

    v = base("flush_en"); v.flush = 1; v.rs = 1; v.rd1 = 32'h5;
    v.eop = ALU_SLL; v.ev = 0; v.erw = 0; vecs.push_back(v);

    // Reset for two cycles with random ID inputs and en = 1.
    v = base("reset");
    drive(v);
    nRST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rdata1 = $urandom;
      id_rdata2 = $urandom; id_imm = 16'($urandom); id_aluop = 4'($urandom);
      id_bsel = 2'($urandom); id_asel = 1'($urandom);
      tick();
      check_bubble($sformatf("reset%0d", i));
    end
    nRST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      check({vecs[i].name, ".alu_a"}, alu_a, vecs[i].ea);
      check({vecs[i].name, ".alu_b"}, alu_b, vecs[i].eb);
      check({vecs[i].name, ".alu_op"}, 32'(alu_op), 32'(vecs[i].eop));
      check({vecs[i].name, ".ex_valid"}, 32'(ex_valid), 32'(vecs[i].ev));
      check({vecs[i].name, ".ex_regwen"}, 32'(ex_regwen), 32'(vecs[i].erw));
      check({vecs[i].name, ".store"}, ex_store_data, vecs[i].est);
      check({vecs[i].name, ".fwd_a"}, 32'(fwd_a_hit), 32'(vecs[i].efa));
      check({vecs[i].name, ".fwd_b"}, 32'(fwd_b_hit), 32'(vecs[i].efb));
    end

    // Stall sequence: a one-cycle MEM/WB forward must persist through the stall.
    v = base("stall"); v.rs = 1; v.rt = 2; v.rd1 = 32'h5; v.rd2 = 32'h7;
    v.wsel = 5'd8;
    drive(v);
    tick();
    check("stall.capture_b", alu_b, 32'h7);
    check("stall.wsel", 32'(ex_wsel), 32'd8);
    en = 1'b0; id_rdata2 = 32'h99;
    memwb_regwen = 1'b1; memwb_wsel = 5'd2; memwb_result = 32'h33;
    tick();
    check("stall.fwd_b", alu_b, 32'h33);
    check("stall.fwd_b_hit", 32'(fwd_b_hit), 32'h1);
    memwb_regwen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("stall.hold%0d_b", i), alu_b, 32'h33);
      check($sformatf("stall.hold%0d_hit", i), 32'(fwd_b_hit), 32'h0);
      check($sformatf("stall.hold%0d_a", i), alu_a, 32'h5);
      check($sformatf("stall.hold%0d_valid", i), 32'(ex_valid), 32'h1);
    end
    en = 1'b1; id_rdata2 = 32'h44;
    tick();
    check("stall.recapture_b", alu_b, 32'h44);

    // Flush during a stall produces a bubble.
    en = 1'b0;
    tick();
    check("stall2.valid", 32'(ex_valid), 32'h1);
    flush = 1'b1;
    tick();
    check_bubble("flush_stall");
    flush = 1'b0;
    en = 1'b1;
    tick();
    check("after_flush.valid", 32'(ex_valid), 32'h1);
    check("after_flush.op", 32'(alu_op), 32'(ALU_ADD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
